// File: rtl/cfa_pkg.sv
// rtl/cfa_pkg.sv - shared mode and direction encodings for CFA green interpolation
package cfa_pkg;

  // Interpolation mode requested by the caller
  localparam logic [1:0] MODE_H     = 2'd0;
  localparam logic [1:0] MODE_V     = 2'd1;
  localparam logic [1:0] MODE_ADAPT = 2'd2;
  localparam logic [1:0] MODE_AVG   = 2'd3;

  // Source actually used for the output sample
  localparam logic [1:0] DIR_H    = 2'd0;
  localparam logic [1:0] DIR_V    = 2'd1;
  localparam logic [1:0] DIR_AVG  = 2'd2;
  localparam logic [1:0] DIR_PASS = 2'd3;

endpackage

// File: rtl/cfa_dir_est.sv
// rtl/cfa_dir_est.sv - one-direction 5-tap green estimate and gradient (two register stages)
module cfa_dir_est #(
  parameter int PIX_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PIX_W-1:0]        m2,
  input  logic [PIX_W-1:0]        m1,
  input  logic [PIX_W-1:0]        c,
  input  logic [PIX_W-1:0]        p1,
  input  logic [PIX_W-1:0]        p2,
  output logic signed [PIX_W+3:0] est,
  output logic [PIX_W+1:0]        grad
);
  import cfa_pkg::*;

  localparam int EST_W  = PIX_W + 4;
  localparam int GRAD_W = PIX_W + 2;

  // All arithmetic is done at EST_W signed; 6*max still fits with headroom
  logic signed [EST_W-1:0] m2_s, m1_s, c_s, p1_s, p2_s;
  logic signed [EST_W-1:0] sum_c, dif_c, lap_c;
  logic signed [EST_W-1:0] sum_q, dif_q, lap_q;
  logic signed [EST_W-1:0] dif_abs, lap_abs;

  assign m2_s = $signed({4'b0000, m2});
  assign m1_s = $signed({4'b0000, m1});
  assign c_s  = $signed({4'b0000, c});
  assign p1_s = $signed({4'b0000, p1});
  assign p2_s = $signed({4'b0000, p2});

  assign sum_c = ((m1_s + p1_s + c_s) <<< 1) - m2_s - p2_s;
  assign dif_c = m1_s - p1_s;
  assign lap_c = (c_s <<< 1) - m2_s - p2_s;

  // Stage 1: register raw sums and differences
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      dif_q <= '0;
      lap_q <= '0;
    end else begin
      sum_q <= sum_c;
      dif_q <= dif_c;
      lap_q <= lap_c;
    end
  end

  assign dif_abs = dif_q[EST_W-1] ? -dif_q : dif_q;
  assign lap_abs = lap_q[EST_W-1] ? -lap_q : lap_q;

  // Stage 2: floor-divide the sum by 4 and form the gradient magnitude
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est  <= '0;
      grad <= '0;
    end else begin
      est  <= sum_q >>> 2;
      grad <= GRAD_W'(dif_abs) + GRAD_W'(lap_abs);
    end
  end

endmodule

// File: rtl/green_hv_adaptive.sv
// rtl/green_hv_adaptive.sv - adaptive H/V green interpolation, 3-cycle pipeline
module green_hv_adaptive #(
  parameter int PIX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] h_m2,
  input  logic [PIX_W-1:0] h_m1,
  input  logic [PIX_W-1:0] h_c,
  input  logic [PIX_W-1:0] h_p1,
  input  logic [PIX_W-1:0] h_p2,
  input  logic [PIX_W-1:0] v_m2,
  input  logic [PIX_W-1:0] v_m1,
  input  logic [PIX_W-1:0] v_c,
  input  logic [PIX_W-1:0] v_p1,
  input  logic [PIX_W-1:0] v_p2,
  input  logic             site_green,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [PIX_W-1:0] out,
  output logic [1:0]       dir
);
  import cfa_pkg::*;

  localparam int GRAD_W = PIX_W + 2;
  localparam int EST_W  = PIX_W + 4;
  localparam int SEL_W  = EST_W + 1;

  logic signed [EST_W-1:0] est_h, est_v;
  logic [GRAD_W-1:0]       grad_h, grad_v;

  logic             v1, v2;
  logic [1:0]       mode1, mode2;
  logic             sg1, sg2;
  logic [PIX_W-1:0] hc1, hc2;

  logic signed [SEL_W-1:0] est_h_x, est_v_x, avg, sel;
  logic signed [SEL_W-1:0] max_val;
  logic [PIX_W-1:0]        out_n;
  logic [1:0]              dir_n;

  cfa_dir_est #(.PIX_W(PIX_W)) u_est_h (
    .clk(clk), .rst(rst),
    .m2(h_m2), .m1(h_m1), .c(h_c), .p1(h_p1), .p2(h_p2),
    .est(est_h), .grad(grad_h)
  );

  cfa_dir_est #(.PIX_W(PIX_W)) u_est_v (
    .clk(clk), .rst(rst),
    .m2(v_m2), .m1(v_m1), .c(v_c), .p1(v_p1), .p2(v_p2),
    .est(est_v), .grad(grad_v)
  );

  // Carry valid, mode, site type and the raw centre alongside the estimator stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      mode1 <= '0;
      mode2 <= '0;
      sg1   <= 1'b0;
      sg2   <= 1'b0;
      hc1   <= '0;
      hc2   <= '0;
    end else begin
      v1    <= in_valid;
      v2    <= v1;
      mode1 <= mode;
      mode2 <= mode1;
      sg1   <= site_green;
      sg2   <= sg1;
      hc1   <= h_c;
      hc2   <= hc1;
    end
  end

  assign est_h_x = SEL_W'(est_h);
  assign est_v_x = SEL_W'(est_v);
  assign avg     = (est_h_x + est_v_x) >>> 1;
  assign max_val = $signed({{(SEL_W-PIX_W){1'b0}}, {PIX_W{1'b1}}});

  // Stage 3 combinational: pick the source by mode, then clamp to the pixel range
  always_comb begin
    sel   = est_h_x;
    dir_n = DIR_H;
    unique case (mode2)
      MODE_H: begin
        sel   = est_h_x;
        dir_n = DIR_H;
      end
      MODE_V: begin
        sel   = est_v_x;
        dir_n = DIR_V;
      end
      MODE_AVG: begin
        sel   = avg;
        dir_n = DIR_AVG;
      end
      MODE_ADAPT: begin
        if (grad_h < grad_v) begin
          sel   = est_h_x;
          dir_n = DIR_H;
        end else if (grad_v < grad_h) begin
          sel   = est_v_x;
          dir_n = DIR_V;
        end else begin
          sel   = avg;
          dir_n = DIR_AVG;
        end
      end
      default: begin
        sel   = est_h_x;
        dir_n = DIR_H;
      end
    endcase

    if (sel < 0)
      out_n = '0;
    else if (sel > max_val)
      out_n = {PIX_W{1'b1}};
    else
      out_n = sel[PIX_W-1:0];

    if (sg2) begin
      out_n = hc2;
      dir_n = DIR_PASS;
    end
  end

  // Stage 3 register: output updates only on valid samples and holds across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      dir       <= '0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out <= out_n;
        dir <= dir_n;
      end
    end
  end

endmodule

// File: tb/tb_green_hv_adaptive.sv
// tb/tb_green_hv_adaptive.sv - directed self-checking bench for green_hv_adaptive
module tb_green_hv_adaptive;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [11:0] h_m2, h_m1, h_c, h_p1, h_p2;
  logic [11:0] v_m2, v_m1, v_c, v_p1, v_p2;
  logic        site_green;
  logic [1:0]  mode;
  logic        out_valid;
  logic [11:0] out;
  logic [1:0]  dir;

  int n_run;
  int n_fail;

  green_hv_adaptive #(.PIX_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .h_m2(h_m2), .h_m1(h_m1), .h_c(h_c), .h_p1(h_p1), .h_p2(h_p2),
    .v_m2(v_m2), .v_m1(v_m1), .v_c(v_c), .v_p1(v_p1), .v_p2(v_p2),
    .site_green(site_green), .mode(mode),
    .out_valid(out_valid), .out(out), .dir(dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [1:0] md, input logic sg,
                       input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
                       input logic [11:0] a3, input logic [11:0] a4,
                       input logic [11:0] b0, input logic [11:0] b1,
                       input logic [11:0] b3, input logic [11:0] b4);
    in_valid   = iv;
    mode       = md;
    site_green = sg;
    h_m2 = a0; h_m1 = a1; h_c = a2; h_p1 = a3; h_p2 = a4;
    v_m2 = b0; v_m1 = b1; v_c = a2; v_p1 = b3; v_p2 = b4;
  endtask

  task automatic drive_adaptive(input logic [1:0] md);
    drive(1'b1, md, 1'b0, 12'd100, 12'd200, 12'd300, 12'd400, 12'd500,
          12'd0, 12'd500, 12'd500, 12'd0);
  endtask

  task automatic drive_flat(input logic [1:0] md);
    drive(1'b1, md, 1'b0, 12'd1000, 12'd1000, 12'd1000, 12'd1000, 12'd1000,
          12'd1000, 12'd1000, 12'd1000, 12'd1000);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
    #3;
    n_run++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_run++;
    if (out !== 12'd0) begin n_fail++; $display("FAIL reset_out got %0d want 0", out); end
    n_run++;
    if (dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir got %0d want 0", dir); end
    wait_edge();
    wait_edge();
    rst = 1'b0;
    wait_edge();
  endtask

  task automatic test_flat();
    drive_flat(2'd2);
    wait_edge();
    idle();
    wait_edge();
    n_run++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flat_early_valid got %0b want 0", out_valid); end
    wait_edge();
    n_run++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flat_valid got %0b want 1", out_valid); end
    n_run++;
    if (out !== 12'd1000) begin n_fail++; $display("FAIL flat_out got %0d want 1000", out); end
    n_run++;
    if (dir !== 2'd2) begin n_fail++; $display("FAIL flat_dir got %0d want 2", dir); end
    wait_edge();
    n_run++;
    if (out_valid !== 1'b0 || out !== 12'd1000 || dir !== 2'd2) begin
      n_fail++;
      $display("FAIL flat_hold got valid=%0b out=%0d dir=%0d want 0/1000/2", out_valid, out, dir);
    end
  endtask

  task automatic test_adaptive();
    drive_adaptive(2'd2);
    wait_edge();
    drive_adaptive(2'd1);
    wait_edge();
    idle();
    wait_edge();
    n_run++;
    if (out_valid !== 1'b1 || out !== 12'd300 || dir !== 2'd0) begin
      n_fail++;
      $display("FAIL adaptive_pick_h got valid=%0b out=%0d dir=%0d want 1/300/0", out_valid, out, dir);
    end
    wait_edge();
    n_run++;
    if (out_valid !== 1'b1 || out !== 12'd650 || dir !== 2'd1) begin
      n_fail++;
      $display("FAIL mode_v got valid=%0b out=%0d dir=%0d want 1/650/1", out_valid, out, dir);
    end
    wait_edge();
  endtask

  task automatic test_average_mode();
    drive_adaptive(2'd3);
    wait_edge();
    idle();
    wait_edge();
    wait_edge();
    n_run++;
    if (out_valid !== 1'b1 || out !== 12'd475 || dir !== 2'd2) begin
      n_fail++;
      $display("FAIL mode_avg got valid=%0b out=%0d dir=%0d want 1/475/2", out_valid, out, dir);
    end
    wait_edge();
  endtask

  task automatic test_clamp();
    drive(1'b1, 2'd0, 1'b0, 12'd0, 12'd4095, 12'd4095, 12'd4095, 12'd0,
          12'd0, 12'd0, 12'd0, 12'd0);
    wait_edge();
    drive(1'b1, 2'd0, 1'b0, 12'd4095, 12'd0, 12'd0, 12'd0, 12'd4095,
          12'd0, 12'd0, 12'd0, 12'd0);
    wait_edge();
    idle();
    wait_edge();
    n_run++;
    if (out_valid !== 1'b1 || out !== 12'd4095 || dir !== 2'd0) begin
      n_fail++;
      $display("FAIL clamp_high got valid=%0b out=%0d dir=%0d want 1/4095/0", out_valid, out, dir);
    end
    wait_edge();
    n_run++;
    if (out_valid !== 1'b1 || out !== 12'd0 || dir !== 2'd0) begin
      n_fail++;
      $display("FAIL clamp_low got valid=%0b out=%0d dir=%0d want 1/0/0", out_valid, out, dir);
    end
    wait_edge();
  endtask

  task automatic test_passthrough();
    drive(1'b1, 2'd2, 1'b1,
          12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 12'd777,
          12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
          12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
          12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    wait_edge();
    idle();
    site_green = 1'b0;
    wait_edge();
    wait_edge();
    n_run++;
    if (out_valid !== 1'b1 || out !== 12'd777 || dir !== 2'd3) begin
      n_fail++;
      $display("FAIL passthrough got valid=%0b out=%0d dir=%0d want 1/777/3", out_valid, out, dir);
    end
    wait_edge();
  endtask

  task automatic test_bubbles();
    logic        exp_v [4];
    logic [11:0] exp_o [4];
    logic [1:0]  exp_d [4];
    exp_v = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_o = '{12'd300, 12'd300, 12'd650, 12'd1000};
    exp_d = '{2'd0, 2'd0, 2'd1, 2'd2};
    drive_adaptive(2'd0);
    for (int j = 1; j <= 6; j++) begin
      wait_edge();
      if (j >= 3) begin
        n_run++;
        if (out_valid !== exp_v[j-3] || out !== exp_o[j-3] || dir !== exp_d[j-3]) begin
          n_fail++;
          $display("FAIL bubbles[%0d] got valid=%0b out=%0d dir=%0d want %0b/%0d/%0d",
                   j-3, out_valid, out, dir, exp_v[j-3], exp_o[j-3], exp_d[j-3]);
        end
      end
      if (j == 1) begin
        idle();
        mode = 2'd3;
      end else if (j == 2) begin
        drive_adaptive(2'd1);
      end else if (j == 3) begin
        drive_flat(2'd2);
      end else begin
        idle();
      end
    end
    wait_edge();
  endtask

  task automatic test_reset_midstream();
    drive_adaptive(2'd0);
    wait_edge();
    drive_adaptive(2'd0);
    wait_edge();
    drive_adaptive(2'd0);
    wait_edge();
    idle();
    n_run++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midstream_pre got %0b want 1", out_valid); end
    rst = 1'b1;
    #1;
    n_run++;
    if (out_valid !== 1'b0 || out !== 12'd0 || dir !== 2'd0) begin
      n_fail++;
      $display("FAIL midstream_async_clear got valid=%0b out=%0d dir=%0d want 0/0/0", out_valid, out, dir);
    end
    wait_edge();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_edge();
      n_run++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midstream_stale[%0d] got %0b want 0", k, out_valid); end
    end
    drive_flat(2'd3);
    wait_edge();
    idle();
    wait_edge();
    n_run++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_early got %0b want 0", out_valid); end
    wait_edge();
    n_run++;
    if (out_valid !== 1'b1 || out !== 12'd1000 || dir !== 2'd2) begin
      n_fail++;
      $display("FAIL post_reset_first got valid=%0b out=%0d dir=%0d want 1/1000/2", out_valid, out, dir);
    end
    wait_edge();
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_flat();
    test_adaptive();
    test_average_mode();
    test_clamp();
    test_passthrough();
    test_bubbles();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/green_hv_adaptive.md
GREEN_HV_ADAPTIVE -- requirements
Module: green_hv_adaptive

Interface
REQ-001 SHALL have parameter PIX_W, default 12, meaning the CFA sample width; legal range 8..16.
REQ-002 SHALL have parameter GRAD_W, default PIX_W+2, meaning the gradient width; not overridable.
REQ-003 SHALL have port clk  input  1  meaning the single rising-edge clock.
REQ-004 SHALL have port rst  input  1  meaning the reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  meaning the tap set is valid this cycle.
REQ-006 SHALL have ports h_m2, h_m1, h_c, h_p1, h_p2  input  PIX_W each  meaning the horizontal 5-tap window, unsigned.
REQ-007 SHALL have ports v_m2, v_m1, v_c, v_p1, v_p2  input  PIX_W each  meaning the vertical 5-tap window, unsigned; v_c equals h_c by construction.
REQ-008 SHALL have port site_green  input  1  meaning the centre sample is already green.
REQ-009 SHALL have port mode  input  2  meaning 0=H-only, 1=V-only, 2=adaptive, 3=average.
REQ-010 SHALL have port out_valid  output  1  meaning out and dir are valid.
REQ-011 SHALL have port out  output  PIX_W  meaning the green estimate, clamped.
REQ-012 SHALL have port dir  output  2  meaning the selected source: 0=H, 1=V, 2=average, 3=passthrough.

Function
REQ-013 SHALL compute, per direction, est = floor((2*m1 + 2*p1 + 2*c - m2 - p2) / 4) as a signed PIX_W+4-bit value, using an arithmetic shift.
REQ-014 SHALL compute, per direction, grad = |m1 - p1| + |2*c - m2 - p2| as an unsigned GRAD_W-bit value with no overflow.
REQ-015 SHALL resolve mode 2 as follows: grad_h < grad_v selects H; grad_v < grad_h selects V; equal gradients select the average.
REQ-016 SHALL compute the average as floor((est_h + est_v) / 2) on signed values, before clamping.
REQ-017 SHALL clamp the selected estimate to [0, 2^PIX_W - 1].
REQ-018 SHALL, when site_green=1, output h_c unmodified with dir=3, ignoring mode.
REQ-019 SHALL be a 3-stage pipeline with a fixed latency of 3 cycles from the in_valid edge to the out_valid edge.
- Stage 1: sums and differences.
- Stage 2: absolute values, est and grad.
- Stage 3: compare, select, clamp, register.
REQ-020 SHALL sample mode and site_green together with the taps and carry them down the pipe, so a mode change affects only later samples.
REQ-021 SHALL pass in_valid bubbles through unchanged; there is no backpressure.
REQ-022 SHALL accept full throughput: one sample per cycle.
REQ-023 SHALL hold out and dir at their last values while out_valid=0.

Reset
REQ-024 SHALL, while rst=1, clear out_valid, out, dir and all pipeline valid bits to 0 asynchronously.
REQ-025 SHALL discard any samples in flight when rst asserts; the first out_valid after release comes 3 cycles after the first post-reset in_valid.

Structure
REQ-026 SHALL take the mode and dir encodings from shared package cfa_pkg as named constants.
REQ-027 SHALL instantiate sub-module cfa_dir_est twice, once per direction.
- cfa_dir_est is parametrised by PIX_W.
- It performs stages 1-2 and outputs est and grad.
REQ-028 SHALL keep selection and clamping in the top level only.

Verification (PIX_W=12)
REQ-029 Flat field: all taps 1000, mode=2, in_valid pulse -> 3 cycles later out_valid=1, out=1000, dir=2.
REQ-030 Adaptive pick: H taps 100,200,300,400,500 (est 300, grad 200); V taps 0,500,300,500,0 (est 650, grad 600); mode=2 -> out=300, dir=0. The same taps with mode=1 -> out=650, dir=1.
REQ-031 Clamping: mode=0, H taps 0,4095,4095,4095,0 -> out=4095. H taps 4095,0,0,0,4095 (est -2048) -> out=0.
REQ-032 Passthrough: site_green=1, h_c=777, mode=2, other taps random -> out=777, dir=3.
REQ-033 Bubbles and mode switch: in_valid 1,0,1,1 with mode 0,x,1,2 -> out_valid 1,0,1,1 starting at cycle +3, each output using its own mode.
REQ-034 Reset mid-stream: assert rst with 3 samples in flight -> out_valid=0 immediately and no stale output after release.
